dmi_jtag_tap: RTL

IEEE 1149.1 TAP controller and instruction decoder feeding the JTAG DMI register stage. It runs the 16-state TAP FSM from `tms_i` and holds the instruction register. It implements the IDCODE, BYPASS and DTMCS data registers locally. When DMIACCESS is selected, it forwards capture/shift/update strobes and TDI to the downstream DMI shift-register stage and muxes that stage's serial output onto TDO.

---
 rtl/dmi_jtag_tap.sv | 88 ++++++++
 1 files changed

// File: rtl/dmi_jtag_tap.sv
// dmi_jtag_tap: IEEE 1149.1 TAP controller with IDCODE/BYPASS/DTMCS registers
// and strobes/TDO muxing for the downstream DMI shift register.
module dmi_jtag_tap #(
  parameter int unsigned IrLength    = 5,
  parameter logic [31:0] IdcodeValue = 32'h0000_0001
) (
  input  logic       tck_i,
  input  logic       trst_ni,
  input  logic       tms_i,
  input  logic       tdi_i,
  output logic       tdo_o,
  output logic       tdo_oe_o,
  input  logic       dmi_tdo_i,
  input  logic [1:0] dmistat_i,
  output logic       dmi_access_o,
  output logic       capture_dr_o,
  output logic       shift_dr_o,
  output logic       update_dr_o,
  output logic       dmi_tdi_o,
  output logic       dmi_reset_o
);
  typedef enum logic [3:0] {
    TestLogicReset, RunTestIdle, SelectDrScan, CaptureDr, ShiftDr, Exit1Dr, PauseDr, Exit2Dr,
    UpdateDr, SelectIrScan, CaptureIr, ShiftIr, Exit1Ir, PauseIr, Exit2Ir, UpdateIr
  } state_e;
  localparam logic [IrLength-1:0] IrIdcode  = IrLength'(5'h01);
  localparam logic [IrLength-1:0] IrDtmcs   = IrLength'(5'h10);
  localparam logic [IrLength-1:0] IrDmi     = IrLength'(5'h11);
  localparam logic [IrLength-1:0] IrCapture = IrLength'(5'b00101);
  state_e              state;
  logic [IrLength-1:0] ir, ir_sr;
  logic [31:0]         dr_sr, dr_capture;
  logic                sel_idcode, sel_dtmcs, sel_bypass;
  assign sel_idcode   = ir == IrIdcode;
  assign sel_dtmcs    = ir == IrDtmcs;
  assign dmi_access_o = ir == IrDmi;
  assign sel_bypass   = !(sel_idcode || sel_dtmcs || dmi_access_o);
  assign dr_capture   = sel_idcode ? IdcodeValue :
                        sel_dtmcs  ? {17'b0, 3'd1, dmistat_i, 6'd7, 4'd1} : 32'b0;
  assign capture_dr_o = dmi_access_o && state == CaptureDr;
  assign shift_dr_o   = dmi_access_o && state == ShiftDr;
  assign update_dr_o  = dmi_access_o && state == UpdateDr;
  assign dmi_tdi_o    = tdi_i;
  // dmireset (bit 16) and dmihardreset (bit 17) both just request a DMI reset
  assign dmi_reset_o  = sel_dtmcs && state == UpdateDr && |dr_sr[17:16];
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state <= TestLogicReset;
      ir    <= IrIdcode;
      ir_sr <= '0;
      dr_sr <= '0;
    end else begin
      unique case (state)
        TestLogicReset: state <= tms_i ? TestLogicReset : RunTestIdle;
        RunTestIdle:    state <= tms_i ? SelectDrScan : RunTestIdle;
        SelectDrScan:   state <= tms_i ? SelectIrScan : CaptureDr;
        CaptureDr:      state <= tms_i ? Exit1Dr : ShiftDr;
        ShiftDr:        state <= tms_i ? Exit1Dr : ShiftDr;
        Exit1Dr:        state <= tms_i ? UpdateDr : PauseDr;
        PauseDr:        state <= tms_i ? Exit2Dr : PauseDr;
        Exit2Dr:        state <= tms_i ? UpdateDr : ShiftDr;
        UpdateDr:       state <= tms_i ? SelectDrScan : RunTestIdle;
        SelectIrScan:   state <= tms_i ? TestLogicReset : CaptureIr;
        CaptureIr:      state <= tms_i ? Exit1Ir : ShiftIr;
        ShiftIr:        state <= tms_i ? Exit1Ir : ShiftIr;
        Exit1Ir:        state <= tms_i ? UpdateIr : PauseIr;
        PauseIr:        state <= tms_i ? Exit2Ir : PauseIr;
        Exit2Ir:        state <= tms_i ? UpdateIr : ShiftIr;
        UpdateIr:       state <= tms_i ? SelectDrScan : RunTestIdle;
      endcase
      if (state == TestLogicReset) ir <= IrIdcode;
      else if (state == UpdateIr) ir <= ir_sr;
      if (state == CaptureIr) ir_sr <= IrCapture;
      else if (state == ShiftIr) ir_sr <= {tdi_i, ir_sr[IrLength-1:1]};
      if (state == CaptureDr) dr_sr <= dr_capture;
      else if (state == ShiftDr) dr_sr <= sel_bypass ? {31'b0, tdi_i} : {tdi_i, dr_sr[31:1]};
    end
  end
  always_ff @(negedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      tdo_o    <= 1'b0;
      tdo_oe_o <= 1'b0;
    end else begin
      tdo_o    <= state == ShiftIr ? ir_sr[0] : dmi_access_o ? dmi_tdo_i : dr_sr[0];
      tdo_oe_o <= state == ShiftIr || state == ShiftDr;
    end
  end
endmodule
